// File: rtl/hilo_pipe_if.sv
// hilo_pipe_if: execute-side bus of the HI/LO write pipeline.
// The pipeline takes the slave view; the driving execute unit takes the master view.
interface hilo_pipe_if;
  logic        ex_hi_we_i;
  logic        ex_lo_we_i;
  logic [31:0] ex_hi_i;
  logic [31:0] ex_lo_i;
  logic        ex_stall_i;
  logic        mem_stall_i;
  logic        flush_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] hi_arch_o;
  logic [31:0] lo_arch_o;
  logic [1:0]  pend_cnt_o;

  modport slave (
    input  ex_hi_we_i, ex_lo_we_i, ex_hi_i, ex_lo_i,
    input  ex_stall_i, mem_stall_i, flush_i,
    output hi_o, lo_o, hi_arch_o, lo_arch_o, pend_cnt_o
  );

  modport master (
    output ex_hi_we_i, ex_lo_we_i, ex_hi_i, ex_lo_i,
    output ex_stall_i, mem_stall_i, flush_i,
    input  hi_o, lo_o, hi_arch_o, lo_arch_o, pend_cnt_o
  );
endinterface

// File: rtl/hilo_pipe.sv
// hilo_pipe: HI/LO writes staged through EX/MEM and MEM/WB slots before committing.
// Optional macro HILO_FWD_EN: hi_o/lo_o return the youngest staged value instead of the committed one.
module hilo_pipe (
  input  logic       clk,
  input  logic       rst,
  hilo_pipe_if.slave bus
);

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } slot_t;

  localparam slot_t BUBBLE = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};

  slot_t       m_q, m_d;
  slot_t       w_q, w_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  function automatic logic [1:0] slot_busy(input slot_t s);
    return {1'b0, s.hi_we | s.lo_we};
  endfunction

`ifdef HILO_FWD_EN
  // Youngest staged write wins; each half is resolved on its own we bit.
  function automatic logic [31:0] fwd_sel(input logic m_we, input logic [31:0] m_val,
                                          input logic w_we, input logic [31:0] w_val,
                                          input logic [31:0] arch);
    logic [31:0] r;
    if (m_we) begin
      r = m_val;
    end else if (w_we) begin
      r = w_val;
    end else begin
      r = arch;
    end
    return r;
  endfunction
`endif

  // EX/MEM slot: flush beats a memory stall, which beats an execute stall.
  always_comb begin
    m_d = m_q;
    if (bus.flush_i) begin
      m_d.hi_we = 1'b0;
      m_d.lo_we = 1'b0;
    end else if (bus.mem_stall_i) begin
      m_d = m_q;
    end else if (bus.ex_stall_i) begin
      m_d = BUBBLE;
    end else begin
      m_d = '{bus.ex_hi_we_i, bus.ex_lo_we_i, bus.ex_hi_i, bus.ex_lo_i};
    end
  end

  // MEM/WB slot: a held EX/MEM slot must not be passed on twice, so a stall inserts a bubble.
  always_comb begin
    w_d = w_q;
    if (bus.flush_i) begin
      w_d.hi_we = 1'b0;
      w_d.lo_we = 1'b0;
    end else if (bus.mem_stall_i) begin
      w_d = BUBBLE;
    end else begin
      w_d = m_q;
    end
  end

  // Commit stage: flush does not stop what already reached MEM/WB.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (w_q.hi_we) begin
      hi_d = w_q.hi;
    end else begin
      hi_d = hi_q;
    end
    if (w_q.lo_we) begin
      lo_d = w_q.lo;
    end else begin
      lo_d = lo_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q  <= BUBBLE;
      w_q  <= BUBBLE;
      hi_q <= 32'h0000_0000;
      lo_q <= 32'h0000_0000;
    end else begin
      m_q  <= m_d;
      w_q  <= w_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.hi_arch_o  = hi_q;
  assign bus.lo_arch_o  = lo_q;
  assign bus.pend_cnt_o = slot_busy(m_q) + slot_busy(w_q);

`ifdef HILO_FWD_EN
  assign bus.hi_o = fwd_sel(m_q.hi_we, m_q.hi, w_q.hi_we, w_q.hi, hi_q);
  assign bus.lo_o = fwd_sel(m_q.lo_we, m_q.lo, w_q.lo_we, w_q.lo, lo_q);
`else
  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_pipe.sv
// tb_hilo_pipe: per-cycle vector table for hilo_pipe plus a hand-written async reset sequence.
`timescale 1ns/1ps
module tb_hilo_pipe;
  logic clk = 1'b0;
  logic rst;
  hilo_pipe_if bus();

  hilo_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Inputs applied during one cycle and the outputs expected during that same cycle.
  typedef struct {
    logic        hwe, lwe;
    logic [31:0] hi, lo;
    logic        exs, ms, fl;
    logic [31:0] ehf, elf, eha, ela;
    logic [1:0]  ep;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input logic hwe, input logic lwe, input logic [31:0] hi, input logic [31:0] lo,
                      input logic exs, input logic ms, input logic fl,
                      input logic [31:0] ehf, input logic [31:0] elf,
                      input logic [31:0] eha, input logic [31:0] ela, input logic [1:0] ep);
    vec_t v;
    v = '{hwe, lwe, hi, lo, exs, ms, fl, ehf, elf, eha, ela, ep};
    vq.push_back(v);
  endtask

  task automatic drive(input logic hwe, input logic lwe, input logic [31:0] hi, input logic [31:0] lo,
                       input logic exs, input logic ms, input logic fl);
    bus.ex_hi_we_i  = hwe;
    bus.ex_lo_we_i  = lwe;
    bus.ex_hi_i     = hi;
    bus.ex_lo_i     = lo;
    bus.ex_stall_i  = exs;
    bus.mem_stall_i = ms;
    bus.flush_i     = fl;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Forwarded expectations apply only when forwarding is built in.
  task automatic check_outs(input string tag, input logic [31:0] ehf, input logic [31:0] elf,
                            input logic [31:0] eha, input logic [31:0] ela, input logic [1:0] ep);
    chk({tag, " hi_o"},      bus.hi_o,       FWD ? ehf : eha);
    chk({tag, " lo_o"},      bus.lo_o,       FWD ? elf : ela);
    chk({tag, " hi_arch_o"}, bus.hi_arch_o,  eha);
    chk({tag, " lo_arch_o"}, bus.lo_arch_o,  ela);
    chk({tag, " pend_cnt"},  {30'd0, bus.pend_cnt_o}, {30'd0, ep});
  endtask

  initial begin
    //    hwe   lwe   hi            lo            exs   ms    fl  | hi_f          lo_f       hi_arch       lo_arch    pend
    push(1'b1, 1'b0, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,     32'h0,        32'h0,     2'd0);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678, 32'h0,     32'h0,        32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678, 32'h0,     32'h0,        32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678, 32'h0,     32'h12345678, 32'h0,     2'd0);
    push(1'b1, 1'b0, 32'hA,        32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678, 32'h0,     32'h12345678, 32'h0,     2'd0);
    push(1'b1, 1'b0, 32'hB,        32'h0,        1'b0, 1'b0, 1'b0, 32'hA,        32'h0,     32'h12345678, 32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'hB,        32'h0,     32'h12345678, 32'h0,     2'd2);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'hB,        32'h0,     32'hA,        32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'hB,        32'h0,     32'hB,        32'h0,     2'd0);
    push(1'b1, 1'b0, 32'h1,        32'h0,        1'b0, 1'b0, 1'b0, 32'hB,        32'h0,     32'hB,        32'h0,     2'd0);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h1,        32'h0,     32'hB,        32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h1,        32'h0,     32'hB,        32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h1,        32'h0,     32'hB,        32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h1,        32'h0,     32'hB,        32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h1,        32'h0,     32'h1,        32'h0,     2'd0);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h1,        32'h0,     32'h1,        32'h0,     2'd0);
    push(1'b0, 1'b1, 32'hDEAD,     32'h55,       1'b0, 1'b0, 1'b0, 32'h1,        32'h0,     32'h1,        32'h0,     2'd0);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h1,        32'h55,    32'h1,        32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h1,        32'h0,     32'h1,        32'h0,     2'd0);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h1,        32'h0,     32'h1,        32'h0,     2'd0);
    push(1'b1, 1'b0, 32'h99,       32'h0,        1'b1, 1'b0, 1'b0, 32'h1,        32'h0,     32'h1,        32'h0,     2'd0);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h1,        32'h0,     32'h1,        32'h0,     2'd0);
    push(1'b0, 1'b1, 32'h0,        32'h77,       1'b0, 1'b0, 1'b0, 32'h1,        32'h0,     32'h1,        32'h0,     2'd0);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h1,        32'h77,    32'h1,        32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h1,        32'h77,    32'h1,        32'h0,     2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h1,        32'h77,    32'h1,        32'h77,    2'd0);
    push(1'b1, 1'b1, 32'h2,        32'h3,        1'b0, 1'b0, 1'b0, 32'h1,        32'h77,    32'h1,        32'h77,    2'd0);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h2,        32'h3,     32'h1,        32'h77,    2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h2,        32'h3,     32'h1,        32'h77,    2'd1);
    push(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h2,        32'h3,     32'h2,        32'h3,     2'd0);

    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #12;
    check_outs("reset", 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    // Inputs change on the falling edge; outputs are checked before the next rising edge.
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].hwe, vq[i].lwe, vq[i].hi, vq[i].lo, vq[i].exs, vq[i].ms, vq[i].fl);
      check_outs($sformatf("vec%0d", i), vq[i].ehf, vq[i].elf, vq[i].eha, vq[i].ela, vq[i].ep);
      @(negedge clk);
    end

    // Two writes in flight, then an asynchronous reset between clock edges.
    drive(1'b1, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0, 32'h22, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("inflight pend_cnt", {30'd0, bus.pend_cnt_o}, 32'd2);
    chk("inflight hi_arch_o", bus.hi_arch_o, 32'h2);
    #2;
    rst = 1'b0;
    #1;
    check_outs("async_rst", 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_outs($sformatf("post_rst%0d", k), 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
